qnigma_alu_arb: RTL

//  Round-robin arbiter/sequencer sharing one qnigma_alu_core among NREQ requesters.
//  - Accepts add/sub/mul jobs, drives core operands, op select and the 1-cycle cal strobe.
//  - Waits for don, then returns res/ovf/eql to the owning requester.
//  - Sits between the crypto-engine microsequencers and the single ALU core instance.

---
 rtl/qnigma_alu_arb.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/qnigma_alu_arb.sv
// qnigma_alu_arb: round-robin sequencer sharing one ALU core among NREQ requesters.
// A single job is in flight at a time. Grant, strobe and response outputs are
// registered, so each is asserted in the cycle where the FSM sits in the
// matching state.
module qnigma_alu_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int TMO  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_opa,
  input  logic [W*NREQ-1:0]   req_opb,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_vld,
  output logic [2*W-1:0]      rsp_res,
  output logic                rsp_ovf,
  output logic                rsp_eql,
  output logic                rsp_err,
  output logic [W-1:0]        core_opa,
  output logic [W-1:0]        core_opb,
  output logic                core_add,
  output logic                core_sub,
  output logic                core_mul,
  output logic                core_cal,
  input  logic [2*W-1:0]      core_res,
  input  logic                core_ovf,
  input  logic                core_eql,
  input  logic                core_don
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 16;
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]   ptr_reg, own_reg;
  logic            tmo_reg;
  logic            wait_tmo;

  logic [NREQ-1:0] gnt_reg, rsp_vld_reg;
  logic [2*W-1:0]  rsp_res_reg;
  logic            rsp_ovf_reg, rsp_eql_reg, rsp_err_reg;
  logic [W-1:0]    core_opa_reg, core_opb_reg;
  logic            core_add_reg, core_sub_reg, core_mul_reg, core_cal_reg;

  logic [1:0]      op_arr  [NREQ];
  logic [W-1:0]    opa_arr [NREQ];
  logic [W-1:0]    opb_arr [NREQ];
  logic [NREQ-1:0] pick_oh, own_oh;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx, cand;
  logic [1:0]      pick_op;

  // Unpack per-requester fields and build one-hot owner/pick vectors.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_arr[gi]  = req_op[2*gi +: 2];
      assign opa_arr[gi] = req_opa[W*gi +: W];
      assign opb_arr[gi] = req_opb[W*gi +: W];
      assign pick_oh[gi] = pick_vld && (pick_idx == PW'(gi));
      assign own_oh[gi]  = (own_reg == PW'(gi));
    end
  endgenerate

  assign pick_op = op_arr[pick_idx];

  // Round-robin pick: first set request at or after the pointer, wrapping.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_reg) + k) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and wait/flush counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wait_tmo   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_vld) state_next = (pick_op == 2'b11) ? RESP : ISSUE;
      end
      ISSUE: begin
        // A done pulse here cannot belong to this job; it is ignored.
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        if (core_don) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_next == TMO_C) begin
            wait_tmo   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        cnt_next   = '0;
        state_next = tmo_reg ? FLUSH : IDLE;
      end
      FLUSH: begin
        // Swallow the late done of the abandoned job, bounded by the timeout.
        cnt_next = cnt_reg + CW'(1);
        if (core_don || (cnt_next == TMO_C)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= '0;
      own_reg      <= '0;
      tmo_reg      <= 1'b0;
      gnt_reg      <= '0;
      rsp_vld_reg  <= '0;
      rsp_res_reg  <= '0;
      rsp_ovf_reg  <= 1'b0;
      rsp_eql_reg  <= 1'b0;
      rsp_err_reg  <= 1'b0;
      core_opa_reg <= '0;
      core_opb_reg <= '0;
      core_add_reg <= 1'b0;
      core_sub_reg <= 1'b0;
      core_mul_reg <= 1'b0;
      core_cal_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= '0;
      rsp_vld_reg  <= '0;
      core_cal_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_vld) begin
            own_reg <= pick_idx;
            gnt_reg <= pick_oh;
            if (pick_op == 2'b11) begin
              // Reserved op never reaches the core; answer with an error at once.
              rsp_vld_reg <= pick_oh;
              rsp_res_reg <= '0;
              rsp_ovf_reg <= 1'b0;
              rsp_eql_reg <= 1'b0;
              rsp_err_reg <= 1'b1;
              tmo_reg     <= 1'b0;
            end else begin
              core_opa_reg <= opa_arr[pick_idx];
              core_opb_reg <= opb_arr[pick_idx];
              core_add_reg <= (pick_op == 2'b00);
              core_sub_reg <= (pick_op == 2'b01);
              core_mul_reg <= (pick_op == 2'b10);
              core_cal_reg <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (core_don) begin
            rsp_vld_reg <= own_oh;
            rsp_res_reg <= core_res;
            rsp_ovf_reg <= core_ovf;
            rsp_eql_reg <= core_eql;
            rsp_err_reg <= 1'b0;
            tmo_reg     <= 1'b0;
          end else if (wait_tmo) begin
            rsp_vld_reg <= own_oh;
            rsp_res_reg <= '0;
            rsp_ovf_reg <= 1'b0;
            rsp_eql_reg <= 1'b0;
            rsp_err_reg <= 1'b1;
            tmo_reg     <= 1'b1;
          end
        end
        RESP: begin
          ptr_reg <= (own_reg == PW'(NREQ - 1)) ? '0 : own_reg + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign rsp_vld  = rsp_vld_reg;
  assign rsp_res  = rsp_res_reg;
  assign rsp_ovf  = rsp_ovf_reg;
  assign rsp_eql  = rsp_eql_reg;
  assign rsp_err  = rsp_err_reg;
  assign core_opa = core_opa_reg;
  assign core_opb = core_opb_reg;
  assign core_add = core_add_reg;
  assign core_sub = core_sub_reg;
  assign core_mul = core_mul_reg;
  assign core_cal = core_cal_reg;

endmodule
